// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package rf_pkg;

   localparam int NUM_REQ  = 4;
   localparam int NUM_REGS = 16;
   localparam int ADDR_W   = $clog2(NUM_REGS);
   localparam int DATA_W   = 32;

   localparam logic [ADDR_W-1:0] ZERO_REG = '0;

   // Writeback requester indices, in round-robin order.
   typedef enum logic [1:0] {
      REQ_ALU  = 2'd0,
      REQ_MD   = 2'd1,
      REQ_LD   = 2'd2,
      REQ_LINK = 2'd3
   } req_id_e;

endpackage

// File: rtl/rf_write_port_arbiter_if.sv
// Requester handshake and register-file write bus of the write-port arbiter.
interface rf_write_port_arbiter_if;
   import rf_pkg::*;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      flush;
   logic                      wr_en;
   logic [ADDR_W-1:0]         wr_sel;
   logic [DATA_W-1:0]         wr_data;
   logic [NUM_REQ-1:0]        grant;
   logic                      busy;

   // Requester / pipeline side
   modport master (
      output req_valid, req_addr, req_data, flush,
      input  req_ready, wr_en, wr_sel, wr_data, grant, busy
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_addr, req_data, flush,
      output req_ready, wr_en, wr_sel, wr_data, grant, busy
   );

endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker: first set request at or above ptr_i, wrapping.
module rr_pick4 (
   input  logic [3:0] req_i,
   input  logic [1:0] ptr_i,
   output logic [3:0] gnt_o,
   output logic [1:0] idx_o
);

   logic [1:0] cand;
   logic       found;

   // Scan ptr_i, ptr_i+1, ... mod 4 and take the first requesting slot.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < 4; k++) begin
         cand = ptr_i + 2'(k);
         if (!found && req_i[cand]) begin
            found        = 1'b1;
            idx_o        = cand;
            gnt_o[cand]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_write_port_arbiter.sv
// Four one-entry writeback slots drained round-robin onto the single register-file write port.
module rf_write_port_arbiter
   import rf_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   rf_write_port_arbiter_if.slave bus
);

   logic [NUM_REQ-1:0] slot_full_q, slot_full_d;
   logic [ADDR_W-1:0]  slot_addr_q [NUM_REQ];
   logic [ADDR_W-1:0]  slot_addr_d [NUM_REQ];
   logic [DATA_W-1:0]  slot_data_q [NUM_REQ];
   logic [DATA_W-1:0]  slot_data_d [NUM_REQ];
   logic [1:0]         rr_ptr_q, rr_ptr_d;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_sel_q, wr_sel_d;
   logic [DATA_W-1:0]  wr_data_q, wr_data_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;

   logic [NUM_REQ-1:0] win_gnt;
   logic [1:0]         win_idx;
   logic [ADDR_W-1:0]  in_addr;

   rr_pick4 u_pick (
      .req_i (slot_full_q),
      .ptr_i (rr_ptr_q),
      .gnt_o (win_gnt),
      .idx_o (win_idx)
   );

   // Ready depends on slot state and flush only, never on req_valid.
   always_comb begin
      bus.req_ready = ~slot_full_q & {NUM_REQ{~bus.flush}};
   end

   // Next state: grant one full slot per cycle, then accept new requests into empty slots.
   always_comb begin
      slot_full_d = slot_full_q;
      slot_addr_d = slot_addr_q;
      slot_data_d = slot_data_q;
      rr_ptr_d    = rr_ptr_q;
      wr_en_d     = 1'b0;
      grant_d     = '0;
      wr_sel_d    = wr_sel_q;
      wr_data_d   = wr_data_q;
      in_addr     = '0;
      if (bus.flush) begin
         slot_full_d = '0;
      end else begin
         if (|slot_full_q) begin
            wr_en_d              = 1'b1;
            wr_sel_d             = slot_addr_q[win_idx];
            wr_data_d            = slot_data_q[win_idx];
            grant_d              = win_gnt;
            slot_full_d[win_idx] = 1'b0;
            rr_ptr_d             = win_idx + 2'd1;
         end
         // A slot being granted has ready low, so grant and refill never collide.
         for (int i = 0; i < NUM_REQ; i++) begin
            in_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            if (bus.req_valid[i] && bus.req_ready[i] && in_addr != ZERO_REG) begin
               slot_full_d[i] = 1'b1;
               slot_addr_d[i] = in_addr;
               slot_data_d[i] = bus.req_data[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Control and output registers; async reset drops any pending write at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot_full_q <= '0;
         rr_ptr_q    <= '0;
         wr_en_q     <= 1'b0;
         wr_sel_q    <= '0;
         wr_data_q   <= '0;
         grant_q     <= '0;
      end else begin
         slot_full_q <= slot_full_d;
         rr_ptr_q    <= rr_ptr_d;
         wr_en_q     <= wr_en_d;
         wr_sel_q    <= wr_sel_d;
         wr_data_q   <= wr_data_d;
         grant_q     <= grant_d;
      end
   end

   // Slot payload is qualified by slot_full_q and needs no reset.
   always_ff @(posedge clock) begin
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
   end

   // Drive the write bus from registered state.
   always_comb begin
      bus.wr_en   = wr_en_q;
      bus.wr_sel  = wr_sel_q;
      bus.wr_data = wr_data_q;
      bus.grant   = grant_q;
      bus.busy    = |slot_full_q;
   end

endmodule

// File: doc/rf_write_port_arbiter.md
Name: rf_write_port_arbiter

Overview:
- Shares the single register-file write port between four writeback requesters: 0 ALU, 1 mult/div, 2 load, 3 link/jal.
- Each requester gets a one-entry holding slot with a valid/ready handshake.
- A round-robin scheduler drains the slots one per cycle.
- Drives the 4-bit write select, write enable and write data of the register-file write decoder (16 registers, register 0 hard-wired to zero).

Parameters:
- NUM_REQ, 4, number of requesters; the design supports exactly 4.
- ADDR_W, 4, register address width (16 registers).
- DATA_W, 32, write data width.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  4  per-requester write request.
- req_addr  in  16  packed addresses; requester i uses bits [4i+3:4i].
- req_data  in  128  packed data; requester i uses bits [32i+31:32i].
- req_ready  out  4  slot i can accept a request this cycle.
- flush  in  1  synchronous discard of all pending slots.
- wr_en  out  1  register-file write enable (registered).
- wr_sel  out  4  register-file write address (registered).
- wr_data  out  32  register-file write data (registered).
- grant  out  4  one-hot requester that owns the current wr_en cycle; 0 when idle.
- busy  out  1  at least one slot is full.

Behaviour:
Reset (async):
- All slots empty; wr_en, wr_sel, wr_data and grant = 0; rr_ptr = 0.
- req_ready = 4'b1111 once reset deasserts; busy = 0.
- Reset during a pending write discards it with no partial write.

Handshake:
- req_ready[i] = ~slot_full[i] & ~flush. It is combinational from state only, never from req_valid.
- Accept when req_valid[i] & req_ready[i] at a rising edge. The slot latches addr and data and sets slot_full[i].
- A request with addr == 0 is accepted but discarded: slot stays empty, no write is issued.

Arbitration, every cycle with any slot_full:
- The winner is the first full slot found searching from rr_ptr upward, modulo 4.
- At the edge: wr_en <= 1, wr_sel <= slot addr, wr_data <= slot data, grant <= onehot(winner), slot_full[winner] <= 0, rr_ptr <= (winner+1) mod 4.
- No slot full: wr_en <= 0, grant <= 0, wr_sel and wr_data hold their values, rr_ptr holds.

Timing:
- Latency: request accepted at edge N; wr_en is visible at the earliest after edge N+1 (2-cycle minimum).
- A slot cannot be granted in its fill cycle.
- Throughput: one write per cycle sustained. A given requester gets at most one write per 2 cycles, because its slot refills the cycle after grant.
- Fairness: with all four slots continuously full, grants rotate 0,1,2,3,0. No requester waits more than 4 grant cycles.

Simultaneous events:
- Granting slot i and refilling slot i in the same cycle cannot happen, since ready is low while the slot is full. The refill lands one cycle later.
- Same address pending in two slots: both writes issue, in round-robin order. Ordering between requesters is the pipeline's responsibility.

flush:
- At the edge, all slots are cleared and no new requests are accepted that cycle.
- The wr_* outputs registered at that edge go idle (wr_en <= 0).
- rr_ptr is unchanged.

busy = |slot_full.

Decomposition:
- Shared package rf_pkg: REQ_ALU=0, REQ_MD=1, REQ_LD=2, REQ_LINK=3, NUM_REGS=16, ZERO_REG=0, ADDR_W, DATA_W.
- Sub-module rr_pick4 (combinational): inputs 4-bit request vector and 2-bit pointer; outputs 4-bit one-hot grant and 2-bit winner index.
- Slots, pointer and output registers stay in the top module.

Test Plan:
- Single request: reset, then req_valid=0001, addr 5, data 0xDEADBEEF for one cycle.
  - Response: wr_en=1, wr_sel=5, wr_data=0xDEADBEEF, grant=0001 exactly 2 cycles after the request edge, then wr_en=0.
  - req_ready[0] is low for exactly one cycle.
- All four at once: addrs 1,2,3,4 on requesters 0..3 in the same cycle.
  - Response: four consecutive wr_en cycles, wr_sel 1,2,3,4, grant 0001,0010,0100,1000; busy falls after the last grant.
- Round-robin rotation: requesters 1 and 3 held continuously valid starting with rr_ptr=2.
  - Response: grant order 1000, 0010, 1000, 0010…; each requester accepted every 2 cycles.
- Zero-register drop: req_valid=0100, addr 0, data 0x1234.
  - Response: accepted (ready stays high), wr_en never asserts, busy stays 0.
- Flush: fill slots 0 and 2 with addrs 7 and 9, then assert flush for 1 cycle before their grant.
  - Response: no writes to 7 or 9, busy=0 after the edge, req_ready=0000 during flush, 1111 after.
- Async reset mid-operation: four slots full, reset asserted between edges.
  - Response: wr_en, grant and busy drop immediately without waiting for clock.
  - After release no stale writes issue; next single request on requester 2 is granted first (rr_ptr=0 search order 0,1,2).
